// File: rtl/pattern_fetch.sv
//------------------------------------------------------------------------------
// Module   : pattern_fetch
// Function : Turns pattern words into in-order main-memory reads and streams
//            the read data back out, bounding outstanding reads with credits.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pattern_fetch #(
  parameter int PDATA_BITS = 24,
  parameter int MDATA_BITS = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pvalid,
  input  logic [PDATA_BITS-1:0] pdata,
  output logic                  pready,
  output logic                  mrvalid,
  output logic [PDATA_BITS-1:0] mraddr,
  input  logic                  mrready,
  input  logic                  mvalid,
  input  logic [MDATA_BITS-1:0] mdata,
  output logic                  dvalid,
  output logic [MDATA_BITS-1:0] ddata,
  input  logic                  dready,
  output logic                  busy,
  output logic                  error,
  output logic [31:0]           count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_one   = CW'(1);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PDATA_BITS-1:0]   r_areg;
  logic                    r_areg_valid;
  logic [CW-1:0]           r_reserved;
  logic [CW-1:0]           r_inflight;
  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;
  logic [MDATA_BITS-1:0]   r_mem [DEPTH];
  logic [31:0]             r_count;

  logic w_acc;
  logic w_req;
  logic w_out;
  logic w_push;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // A response with nothing in flight is dropped and locks the block in ERR.
  always_comb begin
    w_state_nxt = r_state;
    pready      = 1'b0;
    mrvalid     = 1'b0;
    case (r_state)
      ST_RUN: begin
        mrvalid = r_areg_valid && (r_reserved < c_depth);
        pready  = !r_areg_valid || (mrvalid && mrready);
        if (mvalid && (r_inflight == '0)) w_state_nxt = ST_ERR;
      end
      ST_ERR: begin
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_acc  = pvalid && pready;
  assign w_req  = mrvalid && mrready;
  assign w_out  = dvalid && dready;
  assign w_push = mvalid && (r_inflight != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_areg       <= '0;
      r_areg_valid <= 1'b0;
    end else if (w_acc) begin
      r_areg       <= pdata;
      r_areg_valid <= 1'b1;
    end else if (w_req) begin
      r_areg_valid <= 1'b0;
    end
  end

  // reserved counts credits held from request until delivery downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reserved <= '0;
      r_inflight <= '0;
    end else begin
      case ({w_req, w_out})
        2'b10:   r_reserved <= r_reserved + c_one;
        2'b01:   r_reserved <= r_reserved - c_one;
        default: r_reserved <= r_reserved;
      endcase
      case ({w_req, w_push})
        2'b10:   r_inflight <= r_inflight + c_one;
        2'b01:   r_inflight <= r_inflight - c_one;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= mdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_out) begin
        r_rptr  <= r_rptr + 1'b1;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign mraddr = r_areg;
  assign dvalid = (r_wptr != r_rptr);
  assign ddata  = r_mem[r_rptr[AW-1:0]];
  assign busy   = r_areg_valid || (r_reserved != '0);
  assign error  = (r_state == ST_ERR);
  assign count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pattern_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_pattern_fetch
// Function : Directed and randomized bench for pattern_fetch against a
//            queue-based transaction model of the fetch path.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pattern_fetch;
  localparam int PB    = 24;
  localparam int MB    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          pvalid, mrready, mvalid, dready;
  logic [PB-1:0] pdata;
  logic [MB-1:0] mdata;
  logic          pready, mrvalid, dvalid, busy, error;
  logic [PB-1:0] mraddr;
  logic [MB-1:0] ddata;
  logic [31:0]   count;

  pattern_fetch #(.PDATA_BITS(PB), .MDATA_BITS(MB), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .pvalid(pvalid), .pdata(pdata), .pready(pready),
    .mrvalid(mrvalid), .mraddr(mraddr), .mrready(mrready), .mvalid(mvalid),
    .mdata(mdata), .dvalid(dvalid), .ddata(ddata), .dready(dready),
    .busy(busy), .error(error), .count(count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Transaction model: words waiting to be offered, accepted but unrequested,
  // requested but undelivered, and responses scheduled on the memory side.
  logic [PB-1:0] src_q[$];
  logic [PB-1:0] pend_q[$];
  logic [MB-1:0] exp_q[$];
  int            sched_t[$];
  logic [MB-1:0] sched_d[$];
  int            resv, infl, buf_n, last_t, cyc;
  bit            err;
  logic [31:0]   delivered;
  int            mr_pct, dr_pct, lat_lo, lat_hi;
  bit            p_en, spur;
  logic [MB-1:0] dofs;
  int            dut_req, first_acc, first_out, last_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic marks();
    dut_req = 0; first_acc = -1; first_out = -1; last_out = -1;
  endtask

  task automatic eval();
    bit e_mrv, e_prdy, e_dv, acc, req, out;
    int lat, t;
    e_mrv  = !err && (pend_q.size() > 0) && (resv < DEPTH);
    e_prdy = !err && ((pend_q.size() == 0) || (e_mrv && mrready));
    e_dv   = (buf_n > 0);
    chk("pready",  64'(pready),  64'(e_prdy));
    chk("mrvalid", 64'(mrvalid), 64'(e_mrv));
    chk("dvalid",  64'(dvalid),  64'(e_dv));
    chk("busy",    64'(busy),    64'((pend_q.size() > 0) || (resv > 0)));
    chk("error",   64'(error),   64'(err));
    chk("count",   64'(count),   64'(delivered));
    if (e_mrv) chk("mraddr", 64'(mraddr), 64'(pend_q[0]));
    if (e_dv)  chk("ddata",  64'(ddata),  64'(exp_q[0]));
    if (mrvalid === 1'b1 && mrready) dut_req++;
    if (dvalid === 1'b1 && dready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (pvalid && pready === 1'b1 && first_acc < 0) first_acc = cyc;
    acc = pvalid && e_prdy;
    req = e_mrv && mrready;
    out = e_dv && dready;
    if (mvalid) begin
      if (infl == 0) err = 1'b1;
      else begin infl--; buf_n++; end
    end
    if (req) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      t = cyc + lat;
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      sched_t.push_back(t);
      sched_d.push_back(MB'(pend_q[0]) + dofs);
      exp_q.push_back(MB'(pend_q[0]) + dofs);
      void'(pend_q.pop_front());
      resv++; infl++;
    end
    if (out) begin
      void'(exp_q.pop_front());
      buf_n--; resv--; delivered++;
    end
    if (acc) pend_q.push_back(src_q.pop_front());
  endtask

  task automatic advance();
    @(posedge clock);
    cyc++;
    #1;
    mvalid = 1'b0;
    mdata  = $urandom;
    if (spur) begin
      mvalid = 1'b1;
      spur   = 1'b0;
    end else if (sched_t.size() > 0 && sched_t[0] == cyc) begin
      mvalid = 1'b1;
      mdata  = sched_d.pop_front();
      void'(sched_t.pop_front());
    end
    pvalid  = p_en && (src_q.size() > 0);
    pdata   = pvalid ? src_q[0] : '0;
    mrready = int'($urandom_range(99)) < mr_pct;
    dready  = int'($urandom_range(99)) < dr_pct;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    repeat (n) begin eval(); advance(); end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((src_q.size() > 0 || pend_q.size() > 0 || resv > 0) && n < max) begin
      eval(); advance(); n++;
    end
    chk({tag, "_timeout"}, 64'(n < max), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pvalid = 1'b0; mrready = 1'b0; mvalid = 1'b0; dready = 1'b0;
    pdata = '0; mdata = '0;
    src_q.delete(); pend_q.delete(); exp_q.delete(); sched_t.delete(); sched_d.delete();
    resv = 0; infl = 0; buf_n = 0; err = 1'b0; delivered = '0; last_t = cyc; spur = 1'b0;
    @(posedge clock);
    cyc++;
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; p_en = 1'b1; mr_pct = 100; dr_pct = 100; lat_lo = 1; lat_hi = 1; dofs = '0;
    marks();
    do_reset();

    // Reset state and a single word end to end.
    chk("rst_mraddr", 64'(mraddr), 64'(0));
    chk("rst_pready", 64'(pready), 64'(1));
    dofs = 32'hDEADBEEF - 32'h10;
    src_q.push_back(24'h000010);
    marks();
    run(7);
    chk("t1_latency", 64'(last_out - first_acc), 64'(3));
    chk("t1_count", 64'(count), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));

    // Back-to-back stream with one-cycle memory.
    do_reset();
    dofs = 32'h100;
    for (int i = 0; i < 16; i++) src_q.push_back(PB'(i));
    marks();
    drain("t2", 200);
    chk("t2_count", 64'(count), 64'(16));
    chk("t2_rate", 64'(last_out - first_out), 64'(15));

    // Downstream stall: credits cap issued reads at DEPTH.
    do_reset();
    dofs = $urandom; dr_pct = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(PB'(i));
    marks();
    run(20);
    chk("t3_requests", 64'(dut_req), 64'(DEPTH));
    chk("t3_mrvalid", 64'(mrvalid), 64'(0));
    chk("t3_pready", 64'(pready), 64'(0));
    chk("t3_mraddr", 64'(mraddr), 64'(4));
    dr_pct = 100;
    drain("t3", 200);
    chk("t3_count", 64'(count), 64'(8));

    // Randomized handshakes and memory latency.
    do_reset();
    dofs = $urandom; lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 1000; i++) src_q.push_back(PB'($urandom));
    for (int k = 0; k < 80 && (src_q.size() > 0 || pend_q.size() > 0); k++) begin
      mr_pct = int'($urandom_range(100, 20));
      dr_pct = int'($urandom_range(100, 20));
      p_en   = ($urandom_range(9) != 0);
      run(100);
    end
    p_en = 1'b1; mr_pct = 100; dr_pct = 100;
    drain("t4", 2000);
    chk("t4_count", 64'(count), 64'(1000));
    chk("t4_error", 64'(error), 64'(0));

    // Spurious response: sticky error, requests stop, buffered data drains.
    do_reset();
    lat_lo = 1; lat_hi = 1; dr_pct = 0; dofs = $urandom;
    src_q.push_back(24'h0A0000); src_q.push_back(24'h0A0001);
    run(8);
    mr_pct = 0;
    src_q.push_back(24'h0A0002);
    run(3);
    spur = 1'b1;
    run(2);
    chk("t5_error", 64'(error), 64'(1));
    chk("t5_pready", 64'(pready), 64'(0));
    chk("t5_mrvalid", 64'(mrvalid), 64'(0));
    mr_pct = 100; dr_pct = 100;
    run(5);
    chk("t5_drained", 64'(count), 64'(2));
    chk("t5_sticky", 64'(error), 64'(1));
    do_reset();
    chk("t5_rst_error", 64'(error), 64'(0));
    chk("t5_rst_pready", 64'(pready), 64'(1));

    // Reset with three beats buffered and an address held.
    do_reset();
    dr_pct = 0; dofs = $urandom;
    for (int i = 0; i < 5; i++) src_q.push_back(PB'(24'h200 + i));
    run(12);
    mr_pct = 0; dr_pct = 100;
    run(1);
    dr_pct = 0;
    run(1);
    chk("t6_pre_count", 64'(count), 64'(1));
    chk("t6_pre_busy", 64'(busy), 64'(1));
    do_reset();
    chk("t6_dvalid", 64'(dvalid), 64'(0));
    chk("t6_mrvalid", 64'(mrvalid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_pready", 64'(pready), 64'(1));
    mr_pct = 100; dr_pct = 100;
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
